id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/core0_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 33 +++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core0_pkg.sv
// Shared definitions for the core0 pipeline: datapath widths, ALU control
// encodings, decode-side alu_op encodings and the operand forwarding helper.
package core0_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Operation the execute-stage ALU performs
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_ctrl_e;

  // Coarse operation class produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } alu_op_e;

  // Picks the freshest value of a source register. The next-older instruction
  // (MEM) wins over the older one (WB), and x0 always reads the register file
  // copy because it is hard-wired to zero.
  function automatic logic [XLEN-1:0] forward_operand(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       reg_data,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_reg_write,
    input logic [XLEN-1:0]       mem_result,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_reg_write,
    input logic [XLEN-1:0]       wb_result
  );
    logic [XLEN-1:0] value;
    value = reg_data;
    if (rs != '0) begin
      if (mem_reg_write && (mem_rd == rs)) begin
        value = mem_result;
      end else if (wb_reg_write && (wb_rd == rs)) begin
        value = wb_result;
      end
    end
    return value;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decoder: maps alu_op plus funct fields onto an
// ALU operation and flags combinations the ALU cannot execute.
module alu_decoder
  import core0_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_ctrl,
  output logic       illegal_op
);

  // Unsupported combinations fall back to ADD and raise illegal_op
  always_comb begin
    alu_ctrl   = ALU_ADD;
    illegal_op = 1'b0;
    case (alu_op)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          default: illegal_op = 1'b1;
        endcase
      end
      default: illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshakes on both sides, ALU
// control decode at capture time and combinational operand forwarding.
// Forwarding from MEM/WB is compiled in only when ID_EX_FORWARDING_EN is
// defined; otherwise operands come straight from the registered data.
module id_ex_stage
  import core0_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_alu_op,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic                  in_op5,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_alu_src,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            alu_ctrl,
  output logic [XLEN-1:0]       src1,
  output logic [XLEN-1:0]       src2,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  illegal_op
);

  logic                  valid_q;
  logic [2:0]            alu_ctrl_q;
  logic                  illegal_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic                  alu_src_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;

  logic [2:0]            dec_alu_ctrl;
  logic                  dec_illegal;
  logic                  capture;
  logic [XLEN-1:0]       op1;
  logic [XLEN-1:0]       op2;

  alu_decoder u_alu_decoder (
    .alu_op     (in_alu_op),
    .funct3     (in_funct3),
    .funct7b5   (in_funct7b5),
    .op5        (in_op5),
    .alu_ctrl   (dec_alu_ctrl),
    .illegal_op (dec_illegal)
  );

  // The slot can accept whenever it is empty or its occupant leaves this cycle
  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Pipeline register: reset clears everything, flush empties the slot,
  // otherwise capture (possibly replacing a departing entry) or drain
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
      illegal_q   <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      alu_ctrl_q  <= dec_alu_ctrl;
      illegal_q   <= dec_illegal;
      rs1_data_q  <= in_rs1_data;
      rs2_data_q  <= in_rs2_data;
      imm_q       <= in_imm;
      alu_src_q   <= in_alu_src;
      rs1_q       <= in_rs1;
      rs2_q       <= in_rs2;
      rd_q        <= in_rd;
      reg_write_q <= in_reg_write;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // Operands track MEM/WB results every cycle, including while stalled
  always_comb begin
    op1 = forward_operand(rs1_q, rs1_data_q, mem_rd, mem_reg_write, mem_result,
                          wb_rd, wb_reg_write, wb_result);
    op2 = forward_operand(rs2_q, rs2_data_q, mem_rd, mem_reg_write, mem_result,
                          wb_rd, wb_reg_write, wb_result);
  end
`else
  logic unused_fwd_inputs;

  // Without forwarding the register-file copies are used as captured
  always_comb begin
    op1 = rs1_data_q;
    op2 = rs2_data_q;
  end

  assign unused_fwd_inputs = ^{mem_rd, mem_reg_write, mem_result,
                               wb_rd, wb_reg_write, wb_result, rs1_q, rs2_q};
`endif

  assign out_valid     = valid_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign illegal_op    = illegal_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q;
  assign src1          = op1;
  assign store_data    = op2;
  assign src2          = alu_src_q ? imm_q : op2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. Expected forwarding results
// follow ID_EX_FORWARDING_EN so the same bench covers both builds.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic        in_op5;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_alu_src;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        illegal_op;

  int totalChecks  = 0;
  int passedChecks = 0;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [1:0] aluOp;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       op5;
    logic [2:0] expCtrl;
    logic       expIllegal;
  } decodeVec_t;

  decodeVec_t decodeTable[6];

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_funct3     (in_funct3),
    .in_funct7b5   (in_funct7b5),
    .in_op5        (in_op5),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_alu_src    (in_alu_src),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_ctrl      (alu_ctrl),
    .src1          (src1),
    .src2          (src2),
    .store_data    (store_data),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) begin
      passedChecks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic [1:0]  aluOp,  input logic [2:0]  funct3,
    input logic        f7b5,   input logic        op5,
    input logic [31:0] rs1Data, input logic [31:0] rs2Data,
    input logic [31:0] imm,    input logic        aluSrc,
    input logic [4:0]  rs1,    input logic [4:0]  rs2,
    input logic [4:0]  rd,     input logic        regWrite
  );
    in_valid     = 1'b1;
    in_alu_op    = aluOp;
    in_funct3    = funct3;
    in_funct7b5  = f7b5;
    in_op5       = op5;
    in_rs1_data  = rs1Data;
    in_rs2_data  = rs2Data;
    in_imm       = imm;
    in_alu_src   = aluSrc;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_reg_write = regWrite;
  endtask

  task automatic clearForwarding();
    mem_rd        = '0;
    mem_reg_write = 1'b0;
    mem_result    = '0;
    wb_rd         = '0;
    wb_reg_write  = 1'b0;
    wb_result     = '0;
  endtask

  initial begin
    decodeTable[0] = '{2'b10, 3'b111, 1'b0, 1'b0, 3'b010, 1'b0};
    decodeTable[1] = '{2'b10, 3'b110, 1'b0, 1'b0, 3'b011, 1'b0};
    decodeTable[2] = '{2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    decodeTable[3] = '{2'b01, 3'b101, 1'b1, 1'b1, 3'b001, 1'b0};
    decodeTable[4] = '{2'b11, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1};
    decodeTable[5] = '{2'b00, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0};

    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    clearForwarding();
    applyStimulus(2'b10, 3'b111, 1'b0, 1'b0, 32'h1234, 32'h5678, 32'h9, 1'b1,
                  5'd3, 5'd4, 5'd5, 1'b1);
    step();
    step();

    // Reset state, even with in_valid asserted
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal_op}, 32'd0);
    checkOutput("rst_out_rd", {27'd0, out_rd}, 32'd0);
    checkOutput("rst_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("rst_src1", src1, 32'd0);
    checkOutput("rst_src2", src2, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // R-type SUB decode with one-cycle latency
    applyStimulus(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd3, 32'h99, 1'b0,
                  5'd1, 5'd2, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("sub_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("sub_alu_ctrl", {29'd0, alu_ctrl}, 32'd1);
    checkOutput("sub_src1", src1, 32'd5);
    checkOutput("sub_src2", src2, 32'd3);
    checkOutput("sub_store_data", store_data, 32'd3);
    checkOutput("sub_out_rd", {27'd0, out_rd}, 32'd3);
    checkOutput("sub_illegal", {31'd0, illegal_op}, 32'd0);
    step();
    checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Stall: held entry stays stable while a new one waits
    out_ready = 1'b0;
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'h100, 32'h200, 32'd4, 1'b1,
                  5'd8, 5'd9, 5'd5, 1'b1);
    step();
    applyStimulus(2'b01, 3'b000, 1'b0, 1'b0, 32'd7, 32'd2, 32'd0, 1'b0,
                  5'd10, 5'd11, 5'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_src1", src1, 32'h100);
      checkOutput("stall_src2", src2, 32'd4);
      checkOutput("stall_store_data", store_data, 32'h200);
      checkOutput("stall_out_rd", {27'd0, out_rd}, 32'd5);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("b2b_alu_ctrl", {29'd0, alu_ctrl}, 32'd1);
    checkOutput("b2b_src1", src1, 32'd7);
    checkOutput("b2b_out_rd", {27'd0, out_rd}, 32'd6);
    checkOutput("b2b_reg_write", {31'd0, out_reg_write}, 32'd0);

    // Back-to-back decode table at full throughput
    foreach (decodeTable[i]) begin
      applyStimulus(decodeTable[i].aluOp, decodeTable[i].funct3,
                    decodeTable[i].funct7b5, decodeTable[i].op5,
                    32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1);
      step();
      checkOutput("dec_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("dec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, decodeTable[i].expCtrl});
      checkOutput("dec_illegal", {31'd0, illegal_op}, {31'd0, decodeTable[i].expIllegal});
    end

    // Unsupported funct3 under R-type
    applyStimulus(2'b10, 3'b100, 1'b0, 1'b1, 32'd1, 32'd2, 32'd0, 1'b0,
                  5'd1, 5'd2, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    checkOutput("ill_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    checkOutput("ill_flag", {31'd0, illegal_op}, 32'd1);

    // Forwarding priority on rs1, checked during a stall
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'h11, 32'h22, 32'd0, 1'b0,
                  5'd7, 5'd0, 5'd1, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_result = 32'hAA;
    wb_rd  = 5'd7; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
    #1;
    checkOutput("fwd_mem_prio", src1, FWD ? 32'hAA : 32'h11);
    mem_reg_write = 1'b0;
    #1;
    checkOutput("fwd_wb", src1, FWD ? 32'hBB : 32'h11);
    checkOutput("fwd_x0_rs2", store_data, 32'h22);

    // x0 is never forwarded
    out_ready = 1'b1;
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'h33, 32'h44, 32'd0, 1'b0,
                  5'd0, 5'd0, 5'd1, 1'b1);
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hAA;
    wb_rd  = 5'd0; wb_reg_write  = 1'b1; wb_result  = 32'hBB;
    #1;
    checkOutput("fwd_x0_src1", src1, 32'h33);

    // Immediate operand with rs2 forwarded from WB into store_data
    clearForwarding();
    out_ready = 1'b1;
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h55, 32'hFFFFFFFC, 1'b1,
                  5'd0, 5'd9, 5'd2, 1'b0);
    wb_rd = 5'd9; wb_reg_write = 1'b1; wb_result = 32'h10;
    step();
    in_valid = 1'b0;
    checkOutput("imm_src2", src2, 32'hFFFFFFFC);
    checkOutput("imm_store_data", store_data, FWD ? 32'h10 : 32'h55);
    clearForwarding();

    // Flush wins over a simultaneous capture
    applyStimulus(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0,
                  5'd1, 5'd2, 5'd3, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    applyStimulus(2'b10, 3'b110, 1'b0, 1'b0, 32'hDEAD, 32'hBEEF, 32'h77, 1'b1,
                  5'd4, 5'd5, 5'd6, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    checkOutput("mid_rst_out_rd", {27'd0, out_rd}, 32'd0);
    checkOutput("mid_rst_reg_write", {31'd0, out_reg_write}, 32'd0);
    checkOutput("mid_rst_src1", src1, 32'd0);
    checkOutput("mid_rst_src2", src2, 32'd0);
    checkOutput("mid_rst_store_data", store_data, 32'd0);
    rst = 1'b0;
    step();
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
